pe_array_sched: RTL and testbench

Scheduler that sequences a systolic PE array of PE_NUM cells for one Smith-Waterman alignment.
- Latches the query (2 bits per PE) and accepts target characters over a valid/ready stream.
- Generates the per-PE enable wavefront and the newLine pulse, then folds the array's max-score output into a running best score.
- Returns the final score over a valid/ready handshake. Sits between the host/DMA front end and the PE array top level.

---
 rtl/sw_pkg.sv | 21 ++
 rtl/en_wavefront.sv | 35 +++
 rtl/pe_array_sched.sv | 161 ++++++++++++++++
 tb/tb_pe_array_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman PE array scheduler:
// score width, base encodings and scheduler states.
package sw_pkg;

    localparam int unsigned V_E_F_BIT = 10;

    typedef enum logic [1:0] {
        BASE_A = 2'd0,
        BASE_C = 2'd1,
        BASE_G = 2'd2,
        BASE_T = 2'd3
    } base_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/en_wavefront.sv
// PE enable wavefront: lane 0 registers en_in, lane i follows lane i-1 one
// cycle later, and lanes at or beyond the active query length stay at zero.
module en_wavefront #(
    parameter int unsigned PE_NUM = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_in,
    input  logic [$clog2(PE_NUM+1)-1:0]  qlen,
    output logic [PE_NUM-1:0]            en_out
);
    import sw_pkg::*;

    logic [PE_NUM-1:0] sr_q;
    logic [PE_NUM-1:0] sr_d;

    always_comb begin
        sr_d    = '0;
        sr_d[0] = en_in;
        for (int unsigned i = 1; i < PE_NUM; i++) begin
            sr_d[i] = sr_q[i-1] && (i < 32'(qlen));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign en_out = sr_q;

endmodule

// File: rtl/pe_array_sched.sv
// Scheduler for one Smith-Waterman alignment on a PE_NUM-cell systolic array:
// streams target characters, drives the enable wavefront and tracks the best score.
module pe_array_sched #(
    parameter int unsigned PE_NUM    = 2,
    parameter int unsigned V_E_F_BIT = sw_pkg::V_E_F_BIT,
    parameter int unsigned T_LEN_BIT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(PE_NUM+1)-1:0]  q_len,
    input  logic [2*PE_NUM-1:0]          s_in,
    input  logic [T_LEN_BIT-1:0]         t_len,
    output logic                         busy,
    output logic                         cfg_err,
    input  logic                         t_valid,
    input  logic [1:0]                   t_char,
    output logic                         t_ready,
    output logic [2*PE_NUM-1:0]          s_out,
    output logic [1:0]                   t_out,
    output logic                         newline_out,
    output logic [PE_NUM-1:0]            en_out,
    input  logic [V_E_F_BIT-1:0]         result_in,
    output logic [V_E_F_BIT-1:0]         score,
    output logic                         score_valid,
    input  logic                         score_ready
);
    import sw_pkg::*;

    localparam int unsigned QW = $clog2(PE_NUM + 1);
    localparam logic [QW-1:0]        QMAX      = QW'(PE_NUM);
    localparam logic [T_LEN_BIT-1:0] FLUSH_CYC = T_LEN_BIT'(PE_NUM + 1);

    state_e                 state_q, state_d;
    logic [QW-1:0]          qlen_q, qlen_d;
    logic [2*PE_NUM-1:0]    s_out_q, s_out_d;
    logic [T_LEN_BIT-1:0]   rem_q, rem_d;
    logic [T_LEN_BIT-1:0]   flush_q, flush_d;
    logic                   first_q, first_d;
    logic [1:0]             t_out_q, t_out_d;
    logic                   newline_q, newline_d;
    logic                   score_en_q, score_en_d;
    logic [V_E_F_BIT-1:0]   best_q, best_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   transfer;
    logic                   cfg_bad;

    assign transfer = (state_q == RUN) && t_valid && (rem_q != '0);
    assign cfg_bad  = (q_len == '0) || (q_len > QMAX) || (t_len == '0);

    always_comb begin
        state_d    = state_q;
        qlen_d     = qlen_q;
        s_out_d    = s_out_q;
        rem_d      = rem_q;
        flush_d    = flush_q;
        first_d    = first_q;
        t_out_d    = t_out_q;
        newline_d  = 1'b0;
        cfg_err_d  = 1'b0;
        score_en_d = |en_out;
        best_d     = best_q;

        // result_in belongs to the cycle after an enable, hence the delayed strobe
        if (score_en_q && (result_in > best_q)) begin
            best_d = result_in;
        end

        if (transfer) begin
            t_out_d   = t_char;
            newline_d = first_q;
            first_d   = 1'b0;
            rem_d     = rem_q - 1'b1;
            flush_d   = '0;
        end else if (state_q == DRAIN) begin
            flush_d = flush_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        s_out_d = s_in;
                        qlen_d  = q_len;
                        rem_d   = t_len;
                        best_d  = '0;
                        first_d = 1'b1;
                        flush_d = '0;
                    end
                end
            end
            RUN: begin
                if (transfer && (rem_q == T_LEN_BIT'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((en_out == '0) && (flush_q >= FLUSH_CYC)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (score_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            qlen_q     <= '0;
            s_out_q    <= '0;
            rem_q      <= '0;
            flush_q    <= '0;
            first_q    <= 1'b0;
            t_out_q    <= '0;
            newline_q  <= 1'b0;
            score_en_q <= 1'b0;
            best_q     <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            qlen_q     <= qlen_d;
            s_out_q    <= s_out_d;
            rem_q      <= rem_d;
            flush_q    <= flush_d;
            first_q    <= first_d;
            t_out_q    <= t_out_d;
            newline_q  <= newline_d;
            score_en_q <= score_en_d;
            best_q     <= best_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    en_wavefront #(
        .PE_NUM (PE_NUM)
    ) u_en_wavefront (
        .clk    (clk),
        .rst    (rst),
        .en_in  (transfer),
        .qlen   (qlen_q),
        .en_out (en_out)
    );

    assign busy        = (state_q != IDLE);
    assign cfg_err     = cfg_err_q;
    assign t_ready     = (state_q == RUN) && (rem_q != '0);
    assign s_out       = s_out_q;
    assign t_out       = t_out_q;
    assign newline_out = newline_q;
    assign score       = best_q;
    assign score_valid = (state_q == DONE);

endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized self-checking bench for pe_array_sched against a cycle-indexed
// transfer-history model of the enable wavefront, score folding and latency.
module tb_pe_array_sched;

    localparam int PE_NUM = 2;
    localparam int VB     = 10;
    localparam int TB     = 16;
    localparam int QW     = $clog2(PE_NUM + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [QW-1:0]        q_len;
    logic [2*PE_NUM-1:0]  s_in;
    logic [TB-1:0]        t_len;
    logic                 busy;
    logic                 cfg_err;
    logic                 t_valid;
    logic [1:0]           t_char;
    logic                 t_ready;
    logic [2*PE_NUM-1:0]  s_out;
    logic [1:0]           t_out;
    logic                 newline_out;
    logic [PE_NUM-1:0]    en_out;
    logic [VB-1:0]        result_in;
    logic [VB-1:0]        score;
    logic                 score_valid;
    logic                 score_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*PE_NUM-1:0] exp_s;
    logic [1:0]          exp_t_out;

    pe_array_sched #(
        .PE_NUM    (PE_NUM),
        .V_E_F_BIT (VB),
        .T_LEN_BIT (TB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .q_len       (q_len),
        .s_in        (s_in),
        .t_len       (t_len),
        .busy        (busy),
        .cfg_err     (cfg_err),
        .t_valid     (t_valid),
        .t_char      (t_char),
        .t_ready     (t_ready),
        .s_out       (s_out),
        .t_out       (t_out),
        .newline_out (newline_out),
        .en_out      (en_out),
        .result_in   (result_in),
        .score       (score),
        .score_valid (score_valid),
        .score_ready (score_ready)
    );

    always #5 clk = ~clk;

    // One alignment: the model records which cycles carried a transfer and
    // derives enables, newline, score and DONE timing from that history.
    task automatic do_run(input int qlen, input logic [2*PE_NUM-1:0] s, input int tlen,
                          input int vmode, input int rmode, input int hold, input bit noise,
                          output int done_cyc, output logic [VB-1:0] best_out);
        bit                xfer [0:1023];
        int                sent, first_x, last_x, pat_k, cyc, idx;
        logic [PE_NUM-1:0] exp_en, prev_en;
        logic [VB-1:0]     exp_best;
        logic [VB-1:0]     pat [0:3];
        bit                got, exp_sv, exp_nl;
        pat[0] = 10'd3; pat[1] = 10'd7; pat[2] = 10'd5; pat[3] = 10'd6;
        for (int i = 0; i < 1024; i++) xfer[i] = 1'b0;
        sent = 0; first_x = -1; last_x = -1; pat_k = 0; got = 0;
        exp_best = '0; prev_en = '0; done_cyc = -1;
        start = 1'b1; q_len = QW'(qlen); s_in = s; t_len = TB'(tlen);
        t_valid = 1'b0; score_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; exp_s = s;
        n_checks++;
        if (s_out !== exp_s) begin
            n_fail++; $display("FAIL s_out_latch: got %b want %b", s_out, exp_s);
        end
        cyc = 1;
        while (!got && cyc < 600) begin
            for (int i = 0; i < PE_NUM; i++) begin
                idx = cyc - 1 - i;
                exp_en[i] = (i < qlen) && (idx >= 1) && xfer[idx];
            end
            exp_nl = xfer[cyc-1] && ((cyc - 1) == first_x);
            exp_sv = (last_x >= 0) && (sent == tlen) && (cyc >= last_x + PE_NUM + 3);
            n_checks++;
            if (en_out !== exp_en) begin
                n_fail++; $display("FAIL en_out cyc %0d: got %b want %b", cyc, en_out, exp_en);
            end
            n_checks++;
            if (t_ready !== (sent < tlen)) begin
                n_fail++; $display("FAIL t_ready cyc %0d: got %b want %b", cyc, t_ready, sent < tlen);
            end
            n_checks++;
            if (newline_out !== exp_nl) begin
                n_fail++; $display("FAIL newline cyc %0d: got %b want %b", cyc, newline_out, exp_nl);
            end
            n_checks++;
            if (t_out !== exp_t_out) begin
                n_fail++; $display("FAIL t_out cyc %0d: got %0d want %0d", cyc, t_out, exp_t_out);
            end
            n_checks++;
            if ({busy, cfg_err} !== 2'b10) begin
                n_fail++; $display("FAIL busy_cfg cyc %0d: got %b%b want 10", cyc, busy, cfg_err);
            end
            n_checks++;
            if (score_valid !== exp_sv) begin
                n_fail++; $display("FAIL score_valid cyc %0d: got %b want %b", cyc, score_valid, exp_sv);
            end
            if (exp_sv) begin
                got = 1; done_cyc = cyc;
            end else begin
                result_in = VB'($urandom);
                if (|prev_en) begin
                    if (rmode == 1) begin
                        result_in = (pat_k < 4) ? pat[pat_k] : '0;
                        pat_k++;
                    end
                    if (result_in > exp_best) exp_best = result_in;
                end else if (rmode == 1) begin
                    result_in = '1;
                end
                prev_en = exp_en;
                case (vmode)
                    0:       t_valid = 1'b1;
                    1:       t_valid = (cyc % 2) == 1;
                    default: t_valid = 1'($urandom_range(0, 1));
                endcase
                t_char = 2'($urandom);
                if (noise) begin
                    start = 1'($urandom_range(0, 1)); q_len = '0; t_len = '0;
                end
                if (t_valid && sent < tlen) begin
                    xfer[cyc] = 1'b1; sent++; last_x = cyc; exp_t_out = t_char;
                    if (first_x < 0) first_x = cyc;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        best_out = exp_best;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got no score_valid want score_valid by cycle %0d", last_x + PE_NUM + 3);
            start = 1'b0;
            return;
        end
        t_valid = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            n_checks++;
            if ({score_valid, busy, cfg_err, t_ready, en_out} !== {4'b1100, {PE_NUM{1'b0}}}) begin
                n_fail++;
                $display("FAIL done_flags k %0d: got %b%b%b%b %b want 1100 0", k, score_valid, busy, cfg_err, t_ready, en_out);
            end
            n_checks++;
            if (score !== exp_best) begin
                n_fail++; $display("FAIL score_done k %0d: got %0d want %0d", k, score, exp_best);
            end
            score_ready = (k == hold);
            start = (noise && k < hold) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0; score_ready = 1'b0;
        n_checks++;
        if ({score_valid, busy, cfg_err} !== 3'b000) begin
            n_fail++; $display("FAIL after_done: got %b%b%b want 000", score_valid, busy, cfg_err);
        end
        n_checks++;
        if (score !== exp_best) begin
            n_fail++; $display("FAIL score_hold: got %0d want %0d", score, exp_best);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({busy, cfg_err, t_ready, s_out, t_out, newline_out, en_out, score, score_valid} !== '0) begin
            n_fail++;
            $display("FAIL %s: got busy%b err%b rdy%b s%b t%b nl%b en%b sc%0d v%b want all 0", tag,
                     busy, cfg_err, t_ready, s_out, t_out, newline_out, en_out, score, score_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; q_len = '0; s_in = '0; t_len = '0;
        t_valid = 1'b0; t_char = '0; result_in = '0; score_ready = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");
        exp_s = '0; exp_t_out = '0;
    endtask

    task automatic test_reset_mid_run();
        int dc;
        logic [VB-1:0] b;
        start = 1'b1; q_len = QW'(2); s_in = 4'b1011; t_len = TB'(5);
        @(posedge clk); #1;
        start = 1'b0; t_valid = 1'b1; t_char = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (en_out !== 2'b11) begin
            n_fail++; $display("FAIL mid_run_en: got %b want 11", en_out);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset_mid_run");
        #2 rst = 1'b0; t_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle_after_mid_reset");
        exp_s = '0; exp_t_out = '0;
        do_run(2, 4'b0110, 3, 0, 0, 0, 1'b0, dc, b);
    endtask

    task automatic test_basic();
        int dc;
        logic [VB-1:0] b;
        do_run(2, 4'b0100, 4, 0, 1, 0, 1'b0, dc, b);
        n_checks++;
        if (score !== 10'd7) begin
            n_fail++; $display("FAIL basic_score: got %0d want 7", score);
        end
        n_checks++;
        if (dc !== 1 + 4 + PE_NUM + 2) begin
            n_fail++; $display("FAIL basic_latency: got %0d want %0d", dc, 1 + 4 + PE_NUM + 2);
        end
    endtask

    task automatic test_bubbles();
        int dc;
        logic [VB-1:0] b;
        do_run(2, 4'b1110, 3, 1, 0, 1, 1'b0, dc, b);
        n_checks++;
        if (dc !== 5 + PE_NUM + 3) begin
            n_fail++; $display("FAIL bubble_latency: got %0d want %0d", dc, 5 + PE_NUM + 3);
        end
    endtask

    task automatic test_qlen1();
        int dc;
        logic [VB-1:0] b;
        do_run(1, 4'b0011, 5, 2, 0, 0, 1'b0, dc, b);
    endtask

    task automatic test_cfg_err();
        int ql [0:2];
        int tl [0:2];
        ql[0] = 1; tl[0] = 0;
        ql[1] = 3; tl[1] = 4;
        ql[2] = 0; tl[2] = 2;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; q_len = QW'(ql[k]); t_len = TB'(tl[k]); s_in = ~exp_s;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if ({cfg_err, busy} !== 2'b10 || s_out !== exp_s) begin
                n_fail++;
                $display("FAIL cfg_err_pulse %0d: got err%b busy%b s%b want err1 busy0 s%b", k, cfg_err, busy, s_out, exp_s);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({cfg_err, busy} !== 2'b00) begin
                n_fail++; $display("FAIL cfg_err_clear %0d: got err%b busy%b want 00", k, cfg_err, busy);
            end
        end
    endtask

    task automatic test_done_stall();
        int dc;
        logic [VB-1:0] b;
        do_run(2, 4'b1001, 4, 0, 0, 10, 1'b1, dc, b);
    endtask

    task automatic test_random();
        int dc;
        logic [VB-1:0] b;
        for (int r = 0; r < 8; r++) begin
            do_run($urandom_range(1, PE_NUM), 4'($urandom), $urandom_range(1, 10),
                   2, 0, $urandom_range(0, 3), 1'b1, dc, b);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_basic();
        test_bubbles();
        test_qlen1();
        test_cfg_err();
        test_done_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test want end before 2000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
